// File: rtl/seq_mux_n.sv
// seq_mux_n: registered N-to-1 multiplexer with manual select and round-robin auto-scan.
// Optional macro SEQ_MUX_PARITY_EN adds out_par, the registered XOR of the data held in out.
// All outputs come straight from flops; there is no combinational input-to-output path.
module seq_mux_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SELW  = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_bus,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    out,
    output logic            out_valid,
    output logic [SELW-1:0] cur_ch
`ifdef SEQ_MUX_PARITY_EN
    ,
    output logic            out_par
`endif
);

    localparam int unsigned      CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0]  CH_LAST  = SELW'(N - 1);
    localparam logic [SELW:0]    N_EXT    = (SELW + 1)'(N);

    typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_ptr_nxt;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_nxt;
    logic [W-1:0]    r_out;
    logic [SELW-1:0] r_cur_ch;
    logic [SELW-1:0] w_cur_nxt;
    logic            r_valid;
    logic            w_valid_nxt;

    logic            w_sel_legal;
    logic [SELW-1:0] w_start_ch;
    logic [SELW-1:0] w_ptr_adv;
    logic [SELW-1:0] w_idx;
    logic            w_load;
    logic [W-1:0]    w_data;

    // Select legality and the channel a fresh scan starts from.
    always_comb begin
        w_sel_legal = ({1'b0, sel} < N_EXT);
        w_start_ch  = w_sel_legal ? sel : '0;
        w_ptr_adv   = (r_ptr == CH_LAST) ? '0 : r_ptr + SELW'(1);
    end

    // Next-state, pointer/dwell update and which channel (if any) is loaded into out.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_cur_ch;
        w_valid_nxt = 1'b0;
        w_idx       = r_ptr;
        w_load      = 1'b0;
        if (en) begin
            if (!mode) begin
                w_state_nxt = StManual;
                // Illegal select holds out/cur_ch and only drops valid.
                if (w_sel_legal) begin
                    w_idx       = sel;
                    w_load      = 1'b1;
                    w_cur_nxt   = sel;
                    w_valid_nxt = 1'b1;
                end
            end else if (r_state != StScan) begin
                // Entry edge counts as the first dwell cycle of the start channel.
                w_state_nxt = StScan;
                w_ptr_nxt   = w_start_ch;
                w_cnt_nxt   = '0;
                w_idx       = w_start_ch;
                w_load      = 1'b1;
                w_cur_nxt   = w_start_ch;
                w_valid_nxt = 1'b1;
            end else begin
                if (r_cnt == CNT_LAST) begin
                    w_ptr_nxt = w_ptr_adv;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                end
                w_idx       = w_ptr_nxt;
                w_load      = 1'b1;
                w_cur_nxt   = w_ptr_nxt;
                w_valid_nxt = 1'b1;
            end
        end
    end

    // Channel data mux driven by the chosen index.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (w_idx == SELW'(k)) begin
                w_data = in_bus[k*W +: W];
            end
        end
    end

    // State, pointer, dwell counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_cur_ch <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cur_ch <= w_cur_nxt;
            r_valid  <= w_valid_nxt;
            if (w_load) begin
                r_out <= w_data;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign cur_ch    = r_cur_ch;

`ifdef SEQ_MUX_PARITY_EN
    logic r_par;

    // Parity register follows every load of out and holds with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_data;
        end
    end

    assign out_par = r_par;
`endif

endmodule

// File: doc/seq_mux_n.md
Name: seq_mux_n

Overview:
Parametrised registered N-to-1 multiplexer with W-bit channels. It is the sequential successor of the 2:1 mux cell. It supports two modes: manual (external select) and auto-scan (round-robin with a programmable dwell count). It sits between multi-channel sample sources and a single-channel consumer, and reports which channel is currently routed.

Parameters:
N, 4, number of input channels (2..16)
W, 8, data width per channel
SELW, 2, select/channel-index width; must satisfy 2**SELW >= N
DWELL, 4, enabled cycles spent on each channel in scan mode (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_bus  input  N*W  channel k occupies bits [k*W+W-1 : k*W]
sel  input  SELW  manual channel select; also the scan start channel
mode  input  1  0 = manual, 1 = auto-scan
en  input  1  enable; low freezes the block
out  output  W  registered selected data
out_valid  output  1  out holds valid data from a legal channel
cur_ch  output  SELW  channel index that produced the current out

Behaviour:
- Reset (rst_n low, asynchronous): out=0, out_valid=0, cur_ch=0, dwell counter=0, state=IDLE.
- States:
  - IDLE: leaves on the first clk with en=1. Goes to MANUAL if mode=0, or to SCAN if mode=1.
  - MANUAL: goes to SCAN when mode=1 and en=1.
  - SCAN: goes to MANUAL when mode=0 and en=1.
- MANUAL, en=1: on each edge, out <= in_bus[sel], cur_ch <= sel, out_valid <= 1. Latency is 1 cycle from sel/in_bus change to out.
- Illegal select (sel >= N, possible only when N < 2**SELW): out and cur_ch hold, and out_valid <= 0 on that edge.
- Entering SCAN (the edge where mode is first seen as 1): the channel pointer loads sel, or 0 if sel is illegal. The dwell counter clears, and out <= data of that channel.
- SCAN, en=1:
  - Every edge: out <= in_bus[pointer], cur_ch <= pointer, out_valid <= 1. Data tracks the live input of the current channel.
  - The dwell counter increments each enabled cycle. When it reaches DWELL-1, the pointer advances on that same edge and the counter returns to 0. Each channel therefore appears on out for exactly DWELL consecutive enabled cycles.
  - Wrap: the pointer at N-1 advances to 0.
  - DWELL=1: the channel changes on every enabled edge.
- en=0, any state: out, cur_ch, pointer, dwell counter and state all hold. out_valid <= 0 on the next edge. On re-enable, operation resumes with no counter reset, and out_valid returns to 1 one edge later.
- Mode change with en=0 is ignored until en=1. A mode change mid-dwell discards the remaining dwell count.
- sel changes while in SCAN are ignored until the next entry into SCAN.
- rst_n asserted mid-scan clears everything immediately, without waiting for clk. After release the block restarts in IDLE.
- No combinational path from inputs to outputs.

Optional Feature:
Macro SEQ_MUX_PARITY_EN.
- Defined: adds output out_par (1 bit), the registered even parity (XOR reduction) of the data loaded into out. It updates on the same edge as out, holds whenever out holds, and resets to 0.
- Not defined: port out_par is absent. No parity logic is built and all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with nonzero inputs -> out=0, out_valid=0, cur_ch=0 immediately, without a clk edge.
- Manual routing: N=4, W=8, in_bus = {8'hD4, 8'hC3, 8'hB2, 8'hA1}, en=1, mode=0, sel stepping 0..3 one per cycle -> out sequence A1, B2, C3, D4, each one cycle after its sel, with cur_ch equal to the previous cycle's sel and out_valid=1.
- Scan with wrap: DWELL=4, sel=2, switch mode to 1 -> cur_ch sequence is 2 for 4 cycles, 3 for 4 cycles, then 0 and 1 (4 cycles each), then back to 2. out matches the channel data throughout.
- Enable gap: in scan, drop en for 3 cycles after the 2nd cycle on channel 1 -> out_valid=0 during the gap and out/cur_ch frozen. After en returns, channel 1 is held for exactly 2 more valid cycles.
- Illegal select: N=3, SELW=2, mode=0, sel=3 -> out holds its last value and out_valid=0. Switching to mode=1 with sel=3 -> scan starts at channel 0.
- Parity (SEQ_MUX_PARITY_EN defined): route 8'hA1 -> out_par=1. Route 8'hC3 -> out_par=0, on the same edge as out.
